// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with three combinational read ports, one write port,
// a write-protected constant register, a sticky illegal-write flag and a one-entry-per-cycle clear engine.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle legal write data to matching read ports.
module reg_file_param #(
  parameter int                 DATA_W     = 32,
  parameter int                 ADDR_W     = 4,
  parameter int                 DEPTH      = 16,
  parameter int                 PROT_ADDR  = DEPTH - 1,
  parameter logic [DATA_W-1:0]  PROT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] R_Addr_C,
  output logic [DATA_W-1:0] R_Data_A,
  output logic [DATA_W-1:0] R_Data_B,
  output logic [DATA_W-1:0] R_Data_C,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [DATA_W-1:0] W_Data,
  input  logic              Write_Reg,
  input  logic              Clr_Req,
  input  logic              Err_Clr,
  output logic              Busy,
  output logic              Clr_Done,
  output logic              Error_W
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PROT_A   = ADDR_W'(PROT_ADDR);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_legal_s;
  logic              wr_illegal_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  // Upper address bits are zero whenever in_range holds, so the narrow index is exact.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] data;
    data = {DATA_W{1'b0}};
    if (in_range(addr)) begin
      data = regs_q[addr[IDX_W-1:0]];
    end else begin
      data = {DATA_W{1'b0}};
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_legal_s && (addr == W_Addr)) begin
      data = W_Data;
    end else begin
      data = data;
    end
`endif
    return data;
  endfunction

  // Classify the write port; writes while the clear engine runs are neither legal nor illegal.
  always_comb begin
    wr_legal_s   = 1'b0;
    wr_illegal_s = 1'b0;
    if (Write_Reg && !busy_q) begin
      wr_legal_s   = in_range(W_Addr) && (W_Addr != PROT_A);
      wr_illegal_s = !in_range(W_Addr) || (W_Addr == PROT_A);
    end else begin
      wr_legal_s   = 1'b0;
      wr_illegal_s = 1'b0;
    end
  end

  // Next-state: write commit, clear-engine sweep and sticky error tracking.
  always_comb begin
    regs_d  = regs_q;
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (wr_legal_s) begin
          regs_d[W_Addr[IDX_W-1:0]] = W_Data;
        end else begin
          regs_d = regs_q;
        end
        if (Clr_Req) begin
          state_d = CLEAR;
          busy_d  = 1'b1;
          ptr_d   = {ADDR_W{1'b0}};
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CLEAR: begin
        regs_d[ptr_q[IDX_W-1:0]] = (ptr_q == PROT_A) ? PROT_VALUE : {DATA_W{1'b0}};
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ptr_d   = {ADDR_W{1'b0}};
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = {ADDR_W{1'b0}};
      end
    endcase
    // A same-cycle illegal write beats the error clear.
    if (wr_illegal_s) begin
      err_d = 1'b1;
    end else if (Err_Clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State registers with synchronous reset to power-on contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= (i == PROT_ADDR) ? PROT_VALUE : {DATA_W{1'b0}};
      end
      state_q <= IDLE;
      ptr_q   <= {ADDR_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Combinational read ports.
  always_comb begin
    R_Data_A = read_port(R_Addr_A);
    R_Data_B = read_port(R_Addr_B);
    R_Data_C = read_port(R_Addr_C);
  end

  assign Busy     = busy_q;
  assign Clr_Done = done_q;
  assign Error_W  = err_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb_reg_file_param: directed stimulus with literal expectations plus a behavioural model
// checked against every DUT output on each falling edge.
`timescale 1ns/1ps
module tb_reg_file_param;
  localparam int          DW    = 32;
  localparam int          AW    = 5;
  localparam int          DEPTH = 16;
  localparam int          PROT  = 15;
  localparam logic [31:0] PV    = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] R_Addr_A, R_Addr_B, R_Addr_C, W_Addr;
  logic [DW-1:0] R_Data_A, R_Data_B, R_Data_C, W_Data;
  logic          Write_Reg, Clr_Req, Err_Clr;
  logic          Busy, Clr_Done, Error_W;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic [31:0] m_regs [DEPTH];
  bit          m_busy, m_done, m_err;
  int          m_ptr;

  reg_file_param #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PROT_ADDR(PROT), .PROT_VALUE(PV)
  ) dut (
    .clk(clk), .rst(rst),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .R_Addr_C(R_Addr_C),
    .R_Data_A(R_Data_A), .R_Data_B(R_Data_B), .R_Data_C(R_Data_C),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Clr_Req(Clr_Req), .Err_Clr(Err_Clr),
    .Busy(Busy), .Clr_Done(Clr_Done), .Error_W(Error_W)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && (int'(a) != PROT);
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (Write_Reg && !m_busy && addr_ok(W_Addr) && (a == W_Addr)) return W_Data;
`endif
    if (int'(a) < DEPTH) return m_regs[int'(a)];
    return 32'h0;
  endfunction

  // Reference behaviour: one call per rising edge, using inputs held since the previous edge.
  task automatic model_step();
    bit illegal;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_regs[i] = (i == PROT) ? PV : 32'h0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ptr = 0;
    end else begin
      illegal = Write_Reg && !m_busy && !addr_ok(W_Addr);
      m_done  = 1'b0;
      if (m_busy) begin
        m_regs[m_ptr] = (m_ptr == PROT) ? PV : 32'h0;
        m_ptr = m_ptr + 1;
        if (m_ptr == DEPTH) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else begin
        if (Write_Reg && addr_ok(W_Addr)) m_regs[int'(W_Addr)] = W_Data;
        if (Clr_Req) begin
          m_busy = 1'b1;
          m_ptr  = 0;
        end
      end
      if (illegal) m_err = 1'b1;
      else if (Err_Clr) m_err = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("cmp_busy",  32'(Busy),     32'(m_busy));
      check("cmp_done",  32'(Clr_Done), 32'(m_done));
      check("cmp_err",   32'(Error_W),  32'(m_err));
      check("cmp_rd_a",  R_Data_A, model_read(R_Addr_A));
      check("cmp_rd_b",  R_Data_B, model_read(R_Addr_B));
      check("cmp_rd_c",  R_Data_C, model_read(R_Addr_C));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          busy_cnt, done_cnt, guard;
    logic [31:0] exp_byp;
    rst = 1'b1; Write_Reg = 1'b0; Clr_Req = 1'b0; Err_Clr = 1'b0;
    W_Addr = '0; W_Data = '0; R_Addr_A = '0; R_Addr_B = '0; R_Addr_C = '0;
    cyc(); cyc();
    check_en = 1'b1;
    rst = 1'b0;
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_done", 32'(Clr_Done), 32'h0);
    check("rst_err",  32'(Error_W), 32'h0);

    // Reset contents over the full address space, including out-of-range addresses.
    for (int a = 0; a < 32; a++) begin
      cyc();
      R_Addr_A = AW'(a);
      R_Addr_B = AW'(31 - a);
      #1;
      check("rst_read", R_Data_A, (a == PROT) ? PV : 32'h0);
    end

    cyc(); Write_Reg = 1'b1; W_Addr = 5'd3; W_Data = 32'h12345678;
    cyc(); W_Addr = 5'd7; W_Data = 32'hA5A5A5A5;
    cyc(); Write_Reg = 1'b0; R_Addr_A = 5'd3; R_Addr_B = 5'd7; R_Addr_C = 5'd3; #1;
    check("wr_rd_a", R_Data_A, 32'h12345678);
    check("wr_rd_b", R_Data_B, 32'hA5A5A5A5);
    check("wr_rd_c", R_Data_C, 32'h12345678);
    cyc(); R_Addr_C = 5'd20; #1;
    check("oor_read", R_Data_C, 32'h0);

    // Protected-register write, error clear, and set-beats-clear.
    cyc(); Write_Reg = 1'b1; W_Addr = 5'd15; W_Data = 32'h11111111; #1;
    check("err_not_yet", 32'(Error_W), 32'h0);
    cyc(); Write_Reg = 1'b0; R_Addr_A = 5'd15; #1;
    check("prot_keep", R_Data_A, PV);
    check("err_set", 32'(Error_W), 32'h1);
    Err_Clr = 1'b1;
    cyc(); Err_Clr = 1'b0; #1;
    check("err_clr", 32'(Error_W), 32'h0);
    Write_Reg = 1'b1; W_Addr = 5'd20; W_Data = 32'h22222222; Err_Clr = 1'b1;
    cyc(); Write_Reg = 1'b0; Err_Clr = 1'b0; #1;
    check("err_set_wins", 32'(Error_W), 32'h1);
    Err_Clr = 1'b1;
    cyc(); Err_Clr = 1'b0; #1;
    check("err_clr2", 32'(Error_W), 32'h0);

    for (int i = 0; i < 15; i++) begin
      cyc(); Write_Reg = 1'b1; W_Addr = AW'(i); W_Data = 32'(i + 1) * 32'h01010101;
    end
    cyc(); Write_Reg = 1'b0; Clr_Req = 1'b1; R_Addr_A = 5'd0; R_Addr_B = 5'd14; R_Addr_C = 5'd15;
    cyc(); Clr_Req = 1'b0; #1;
    check("clr_busy0", 32'(Busy), 32'h1);
    check("clr_old0", R_Data_A, 32'h01010101);
    busy_cnt = 1; done_cnt = 0; guard = 0;
    while (Busy === 1'b1 && guard < 40) begin
      cyc();
      guard++;
      if (Busy) busy_cnt++;
      if (Clr_Done) done_cnt++;
      if (busy_cnt == 2 && Busy) begin
        check("clr_prog_r0",  R_Data_A, 32'h0);
        check("clr_prog_r14", R_Data_B, 32'h0F0F0F0F);
      end
      // Mid-clear write and clear request must both be ignored.
      if (busy_cnt == 8 && Busy) begin
        Write_Reg = 1'b1; W_Addr = 5'd2; W_Data = 32'hBAD0BAD0; Clr_Req = 1'b1;
      end else begin
        Write_Reg = 1'b0; Clr_Req = 1'b0;
      end
    end
    check("clr_end_busy",  32'(Busy), 32'h0);
    check("clr_busy_cnt",  32'(busy_cnt), 32'd16);
    check("clr_done_hi",   32'(Clr_Done), 32'h1);
    check("clr_done_cnt",  32'(done_cnt), 32'd1);
    Write_Reg = 1'b0; Clr_Req = 1'b0; R_Addr_A = 5'd2;
    cyc(); #1;
    check("clr_done_lo", 32'(Clr_Done), 32'h0);
    check("clr_no_err",  32'(Error_W), 32'h0);
    check("clr_r2_drop", R_Data_A, 32'h0);
    check("clr_r15",     R_Data_C, PV);

    // Reset in the middle of a clear, with the pointer at 5.
    cyc(); Write_Reg = 1'b1; W_Addr = 5'd5; W_Data = 32'h55555555;
    cyc(); W_Addr = 5'd9; W_Data = 32'h99999999;
    cyc(); Write_Reg = 1'b0; Clr_Req = 1'b1; R_Addr_A = 5'd9; R_Addr_B = 5'd15;
    cyc(); Clr_Req = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc(); rst = 1'b0; #1;
    check("mrst_busy", 32'(Busy), 32'h0);
    check("mrst_done", 32'(Clr_Done), 32'h0);
    check("mrst_r9",   R_Data_A, 32'h0);
    check("mrst_r15",  R_Data_B, PV);
    cyc(); #1;
    check("mrst_idle", 32'(Busy), 32'h0);

    // Same-cycle forwarding of a legal write; an illegal write is never forwarded.
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'hCAFEF00D;
`else
    exp_byp = 32'h44444444;
`endif
    cyc(); Write_Reg = 1'b1; W_Addr = 5'd4; W_Data = 32'h44444444;
    cyc(); W_Data = 32'hCAFEF00D; R_Addr_A = 5'd4; #1;
    check("byp_same", R_Data_A, exp_byp);
    cyc(); Write_Reg = 1'b0; #1;
    check("byp_after", R_Data_A, 32'hCAFEF00D);
    Write_Reg = 1'b1; W_Addr = 5'd15; W_Data = 32'h0BADF00D; R_Addr_B = 5'd15; #1;
    check("byp_illegal", R_Data_B, PV);
    cyc(); Write_Reg = 1'b0; #1;
    check("byp_ill_err", 32'(Error_W), 32'h1);

    repeat (2) cyc();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
